// File: rtl/csa_resolve_16b.sv
// Digit-serial carry-propagate resolver: turns a CSA (sum, carry) pair into s + 2*carry.
// Optional overflow flag output is enabled by defining CSA_RESOLVE_OVF_EN.
module csa_resolve_16b #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result
`ifdef CSA_RESOLVE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned RW     = WIDTH + 2;
    localparam int unsigned NCHUNK = (RW + CHUNK - 1) / CHUNK;
    localparam int unsigned PW     = NCHUNK * CHUNK;
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   opa_q, opa_d;
    logic [PW-1:0]   opb_q, opb_d;
    logic [PW-1:0]   res_q, res_d;
    logic            cy_q, cy_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CHUNK:0]  chunk_sum;
    logic [31:0]     base;
    logic            last_chunk;

    assign last_chunk = (idx_q == IW'(NCHUNK - 1));

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        cy_d      = cy_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        base      = 32'(idx_q) * CHUNK;
        chunk_sum = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, cy_q};

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opa_d   = PW'(s);
                    opb_d   = PW'({carry, 1'b0});
                    cy_d    = 1'b0;
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                res_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                cy_d  = chunk_sum[CHUNK];
                opa_d = opa_q >> CHUNK;
                opb_d = opb_q >> CHUNK;
                idx_d = idx_q + 1'b1;
                // The final carry-out cannot be set: 3*(2^WIDTH-1) fits in WIDTH+2 bits.
                if (last_chunk) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
        end
    end

    assign result = res_q[RW-1:0];

    // Padding bits above WIDTH+1 always stay zero and are not exported.
    if (PW > RW) begin : gen_pad
        logic unused_pad;
        assign unused_pad = ^res_q[PW-1:RW];
    end

`ifdef CSA_RESOLVE_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StBusy && last_chunk) begin
            ovf_d = |res_d[RW-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_resolve_16b.sv
// Scoreboard bench for csa_resolve_16b: random and directed pairs against an arithmetic model,
// plus CHUNK=1 and CHUNK=18 instances for the latency sweep.
module tb_csa_resolve_16b;

    localparam int unsigned NCHUNK = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] s_i;
    logic [15:0] carry_i;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] result;
`ifdef CSA_RESOLVE_OVF_EN
    logic        ovf;
`endif

    logic        x_in_valid;
    logic [15:0] x_s;
    logic [15:0] x_carry;
    logic        c1_in_ready, c1_out_valid;
    logic        c18_in_ready, c18_out_valid;
    logic [17:0] c1_result, c18_result;
`ifdef CSA_RESOLVE_OVF_EN
    logic        c1_ovf, c18_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_bp = 0;
    bit prev_ov = 0;

    int unsigned exp_res_q[$];
    int          exp_rise_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_resolve_16b #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s_i),
        .carry     (carry_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef CSA_RESOLVE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    csa_resolve_16b #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (x_in_valid),
        .in_ready  (c1_in_ready),
        .s         (x_s),
        .carry     (x_carry),
        .out_valid (c1_out_valid),
        .out_ready (1'b1),
        .result    (c1_result)
`ifdef CSA_RESOLVE_OVF_EN
        ,
        .ovf       (c1_ovf)
`endif
    );

    csa_resolve_16b #(.WIDTH(16), .CHUNK(18)) u_c18 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (x_in_valid),
        .in_ready  (c18_in_ready),
        .s         (x_s),
        .carry     (x_carry),
        .out_valid (c18_out_valid),
        .out_ready (1'b1),
        .result    (c18_result)
`ifdef CSA_RESOLVE_OVF_EN
        ,
        .ovf       (c18_ovf)
`endif
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair; returns just after the edge that accepts it.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        s_i      = a;
        carry_i  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            exp_res_q.push_back(int'(a) + 2 * int'(b));
            exp_rise_q.push_back(cyc + 1 + NCHUNK);
        end
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_res_q.size() != 0 || !in_ready) && n < 500) begin
            tick();
            n++;
        end
        check(name, exp_res_q.size(), 0);
    endtask

    // Monitor: latency on each rising out_valid, value on each output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (exp_rise_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("latency", cyc, exp_rise_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_output", result, 0);
                end else begin
                    int unsigned e;
                    e = exp_res_q.pop_front();
                    check("result", result, e);
`ifdef CSA_RESOLVE_OVF_EN
                    check("ovf", ovf, (e >= 32'h1_0000) ? 1 : 0);
`endif
                end
            end
        end
        prev_ov = out_valid && !rst;
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #2 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        int lat1, lat18;
        logic [17:0] r1, r18;

        rst        = 1'b1;
        in_valid   = 1'b0;
        s_i        = '0;
        carry_i    = '0;
        out_ready  = 1'b1;
        x_in_valid = 1'b0;
        x_s        = '0;
        x_carry    = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);

        // Basic
        send(16'h00FF, 16'h0001);
        in_valid = 1'b0;
        check("basic_in_ready_drop", in_ready, 0);
        wait_drain("basic_drain");

        // Max value
        send(16'hFFFF, 16'hFFFF);
        in_valid = 1'b0;
        wait_drain("max_drain");

        // Backpressure with an ignored offer during the hold
        out_ready = 1'b0;
        send(16'h1234, 16'h0000);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            s_i      = 16'h5555;
            carry_i  = 16'h0000;
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_result", result, 18'h01234);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        repeat (8) tick();
        check("bp_ignored_offer", out_valid, 0);
        check("bp_queue_empty", exp_res_q.size(), 0);

        // Reset mid-operation
        send(16'hAAAA, 16'h5555);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        exp_res_q.delete();
        exp_rise_q.delete();
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        send(16'h0003, 16'h0002);
        in_valid = 1'b0;
        wait_drain("midrst_drain");

        // Back-to-back with in_valid held high
        send(16'h0001, 16'h0001);
        send(16'h8000, 16'h8000);
        send(16'h0000, 16'h0000);
        in_valid = 1'b0;
        wait_drain("b2b_drain");

        // Random traffic with random output backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 8 == 3) a = 16'hFFFF;
            if (i % 8 == 5) b = 16'hFFFF;
            send(a, b);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_bp = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_drain("rand_drain");

        // CHUNK sweep
        lat1  = -1;
        lat18 = -1;
        r1    = '0;
        r18   = '0;
        x_s        = 16'hFFFF;
        x_carry    = 16'h0001;
        x_in_valid = 1'b1;
        tick();
        x_in_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (c1_out_valid && lat1 < 0) begin
                lat1 = k;
                r1   = c1_result;
            end
            if (c18_out_valid && lat18 < 0) begin
                lat18 = k;
                r18   = c18_result;
            end
        end
        check("chunk1_latency", lat1, 18);
        check("chunk1_result", r1, 32'h0FFFF + 2 * 32'h00001);
        check("chunk18_latency", lat18, 1);
        check("chunk18_result", r18, 32'h0FFFF + 2 * 32'h00001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
